// File: rtl/branch_unit.sv
// Branch/jump resolution unit: accepts a request with ULA flags, resolves the
// condition and target in one cycle, then redirects the PC and holds a fetch flush.
module branch_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] CNT_RST_VAL  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] pc_i,
  input  logic [63:0] imm_i,
  input  logic [63:0] rs1_i,
  input  logic [5:0]  flags_i,
  output logic        resolve_valid_o,
  output logic        taken_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  output logic [63:0] link_addr_o,
  output logic        misaligned_o,
  output logic        illegal_o,
  output logic        flush_o,
  output logic [31:0] taken_count_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_FLUSH   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept_s, cond_s, illegal_s, taken_s, misalign_s, redirect_s;
  logic [63:0] target_s;

  logic        req_ready_q, req_ready_d;
  logic        resolve_valid_q, resolve_valid_d;
  logic        taken_q, taken_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic [63:0] link_addr_q, link_addr_d;
  logic        misaligned_q, misaligned_d;
  logic        illegal_q, illegal_d;
  logic        flush_q, flush_d;
  logic [31:0] taken_count_q, taken_count_d;

  assign accept_s = req_valid_i && req_ready_q;

  // Resolution is computed from the request itself so every pulse leaves a register.
  always_comb begin
    cond_s    = 1'b0;
    illegal_s = 1'b0;
    case (funct3_i)
      3'b000:         cond_s = flags_i[0];
      3'b001:         cond_s = flags_i[1];
      3'b100:         cond_s = flags_i[2];
      3'b101:         cond_s = flags_i[3];
      3'b110:         cond_s = flags_i[4];
      3'b111:         cond_s = flags_i[5];
      3'b010, 3'b011: illegal_s = 1'b1;
      default:        cond_s = 1'b0;
    endcase
    if (is_jalr_i) begin
      target_s  = (rs1_i + imm_i) & ~64'd1;
      taken_s   = 1'b1;
      illegal_s = 1'b0;
    end else if (is_jal_i) begin
      target_s  = pc_i + imm_i;
      taken_s   = 1'b1;
      illegal_s = 1'b0;
    end else begin
      target_s  = pc_i + imm_i;
      taken_s   = cond_s;
    end
    misalign_s = taken_s && (target_s[1:0] != 2'b00);
    redirect_s = taken_s && !misalign_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and flush countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_RESOLVE;
        else          state_d = S_IDLE;
      end
      S_RESOLVE: begin
        if (redirect_valid_q) begin
          state_d = S_FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values; redirect_pc/link_addr only change on an accepted request.
  always_comb begin
    req_ready_d      = (state_d == S_IDLE);
    flush_d          = (state_d == S_FLUSH);
    resolve_valid_d  = accept_s;
    taken_d          = accept_s && taken_s;
    redirect_valid_d = accept_s && redirect_s;
    misaligned_d     = accept_s && misalign_s;
    illegal_d        = accept_s && illegal_s;
    if (accept_s) begin
      redirect_pc_d = target_s;
      link_addr_d   = pc_i + 64'd4;
    end else begin
      redirect_pc_d = redirect_pc_q;
      link_addr_d   = link_addr_q;
    end
    if (accept_s && redirect_s && (taken_count_q != 32'hFFFF_FFFF)) begin
      taken_count_d = taken_count_q + 32'd1;
    end else begin
      taken_count_d = taken_count_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_q      <= 1'b1;
      resolve_valid_q  <= 1'b0;
      taken_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 64'd0;
      link_addr_q      <= 64'd0;
      misaligned_q     <= 1'b0;
      illegal_q        <= 1'b0;
      flush_q          <= 1'b0;
      taken_count_q    <= CNT_RST_VAL;
    end else begin
      req_ready_q      <= req_ready_d;
      resolve_valid_q  <= resolve_valid_d;
      taken_q          <= taken_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      link_addr_q      <= link_addr_d;
      misaligned_q     <= misaligned_d;
      illegal_q        <= illegal_d;
      flush_q          <= flush_d;
      taken_count_q    <= taken_count_d;
    end
  end

  assign req_ready_o      = req_ready_q;
  assign resolve_valid_o  = resolve_valid_q;
  assign taken_o          = taken_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign link_addr_o      = link_addr_q;
  assign misaligned_o     = misaligned_q;
  assign illegal_o        = illegal_q;
  assign flush_o          = flush_q;
  assign taken_count_o    = taken_count_q;

endmodule

// File: doc/branch_unit.md
# branch_unit

Resolves conditional branches and jumps for the processor datapath by consuming the six comparison flags the ULA produces. It latches a branch/jump request with its flags, selects the condition from funct3, computes the target, and issues a one-cycle PC redirect. On a taken redirect it holds a fetch flush for a programmable number of cycles. It sits between decode/ULA and the PC/fetch logic.

## Interface
- FLUSH_CYCLES, 2: cycles `flush` stays high after a taken redirect, legal range 1..15.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- is_jal  in  1  request is JAL.
- is_jalr  in  1  request is JALR.
- funct3  in  3  branch condition, used when neither is_jal nor is_jalr.
- pc  in  64  PC of the branch instruction.
- imm  in  64  sign-extended immediate.
- rs1  in  64  rs1 value, used for JALR.
- flags  in  6  ULA flags: bit0 BEQ, bit1 BNE, bit2 BLT, bit3 BGE, bit4 BLTU, bit5 BGEU.
- resolve_valid  out  1  one-cycle pulse: resolution outputs are valid.
- taken  out  1  branch/jump taken (qualified by resolve_valid).
- redirect_valid  out  1  one-cycle pulse: load redirect_pc into PC.
- redirect_pc  out  64  target address.
- link_addr  out  64  pc+4 of the request, for the rd writeback of JAL/JALR.
- misaligned  out  1  one-cycle pulse: taken target with bits[1:0] != 0.
- illegal  out  1  one-cycle pulse: funct3 is 010 or 011 on a conditional branch.
- flush  out  1  fetch/decode flush.
- taken_count  out  32  saturating count of taken redirects.

## Operation
- States:
  - IDLE: req_ready=1.
  - RESOLVE: exactly one cycle.
  - FLUSH: lasts FLUSH_CYCLES cycles.
- Accept: `req_valid && req_ready` at an edge latches is_jal, is_jalr, funct3, pc, imm, rs1 and flags, then moves to RESOLVE. Inputs are ignored outside IDLE.
- Priority in RESOLVE: is_jalr > is_jal > conditional.
- Condition select:
  - 000→flags[0], 001→flags[1], 100→flags[2], 101→flags[3], 110→flags[4], 111→flags[5].
  - 010/011 → taken=0 and illegal=1.
- JAL and JALR are always taken.
- Targets, 64-bit modulo 2^64, wrap ignored:
  - branch/JAL: pc+imm.
  - JALR: (rs1+imm) with bit0 cleared.
- link_addr = pc+4 (wraps at 2^64).
- RESOLVE outputs:
  - Always: resolve_valid=1.
  - Taken and target[1:0]==0: redirect_valid=1, taken_count increments (saturates at 0xFFFF_FFFF), next state FLUSH.
  - Taken and misaligned: misaligned=1, redirect_valid=0, taken=1, no count, next state IDLE.
  - Not taken or illegal: next state IDLE.
- FLUSH: flush=1. A 4-bit counter loads FLUSH_CYCLES-1 on entry and decrements; leave to IDLE when it reaches 0.
- redirect_pc and link_addr hold their last value until the next RESOLVE.

## Timing
- Reset values: req_ready=1 once rst_n is high and the state is IDLE; all other outputs 0, taken_count=0, state IDLE.
- Reset acts immediately when asserted, mid-RESOLVE or mid-FLUSH; pending pulses are dropped.
- Accept at edge N → RESOLVE during cycle N+1 → pulses valid for exactly cycle N+1.
- Taken: flush high for cycles N+2..N+1+FLUSH_CYCLES; req_ready returns high at cycle N+2+FLUSH_CYCLES.
- Not taken: req_ready high again at cycle N+2, giving back-to-back throughput of one request per 2 cycles.
- req_ready is low during RESOLVE and FLUSH; req_valid held high there is not consumed.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- BEQ, funct3=000, flags=6'b101001, pc=0x1000, imm=0x20, accept at N → N+1: resolve_valid=1, taken=1, redirect_valid=1, redirect_pc=0x1020, link_addr=0x1004; flush high for N+2..N+3 (FLUSH_CYCLES=2); req_ready high at N+4; taken_count=1.
- BLTU, funct3=110, flags=6'b100110 → taken=0, redirect_valid=0, no flush, req_ready=1 at N+2.
- JALR with rs1=0x2003, imm=0x4 → target 0x2007 with bit0 cleared = 0x2006, misaligned=1, redirect_valid=0, taken_count unchanged, IDLE at N+2.
- funct3=010 → illegal=1, taken=0, no redirect; JAL with pc=0xFFFF_FFFF_FFFF_FFFC, imm=8 → redirect_pc=0x4, link_addr=0x0.
- Hold req_valid=1 through a taken branch: second request is accepted only at N+4; changing the flags input during FLUSH does not change the first result.
- Drop rst_n during FLUSH → flush=0, req_ready=1, state IDLE asynchronously; taken_count=0. Preload the counter near 0xFFFF_FFFF and apply 3 taken redirects → saturates at 0xFFFF_FFFF.
